maxnet_controller: RTL

Sequencing FSM for the four-neuron MaxNet winner-take-all datapath. It loads the four IEEE-754 single-precision inputs, then runs update iterations. Each iteration steps the shared floating-point update unit over neurons 0..3 with a req/ack handshake and commits the new activations. It stops when at most one activation is still positive or an iteration cap is reached, then reports the winner index. It sits between the top-level start/done interface and the activation register bank plus FP unit.

---
 rtl/maxnet_controller.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/maxnet_controller.sv
// ---------------------------------------------------------------------------
// maxnet_controller
//
// Sequencing FSM for a four-neuron MaxNet winner-take-all datapath. It loads
// the four inputs into the activation bank, then repeatedly steps a shared FP
// update unit over neurons 0..3 (req/ack), writes each result into a shadow
// register and finally commits all four shadows at once. The run stops when
// at most one activation is still positive, or when MAX_ITER iterations have
// been committed, and reports the surviving neuron.
//
// Handshake: fp_req is held high, with calc_idx stable, until fp_ack is
// sampled high on a rising edge; that edge completes the transfer. fp_req
// then drops for exactly one cycle (WRITE, wr_en=1) before the next request.
// fp_ack is ignored whenever fp_req is low.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   begin a run (honoured only in IDLE or DONE)
//   pos_flags  in   bit i = committed activation i is strictly positive
//   fp_ack     in   FP unit result for calc_idx is ready
//   ld_x       out  load x1..x4 into the activation registers
//   fp_req     out  request an update for neuron calc_idx
//   calc_idx   out  neuron currently being updated
//   wr_en      out  write FP result into shadow register calc_idx
//   commit     out  copy the four shadow registers into the activations
//   done       out  run finished, held until the next start
//   winner     out  index of the surviving neuron
//   win_valid  out  exactly one neuron survived
//   timeout    out  run ended because MAX_ITER was reached
//   iter_cnt   out  committed iterations in the current or last run
//   dbg_state  out  current FSM state encoding
// ---------------------------------------------------------------------------
module maxnet_controller #(
  parameter int ITER_W   = 5,
  parameter int MAX_ITER = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        pos_flags,
  input  logic              fp_ack,
  output logic              ld_x,
  output logic              fp_req,
  output logic [1:0]        calc_idx,
  output logic              wr_en,
  output logic              commit,
  output logic              done,
  output logic [1:0]        winner,
  output logic              win_valid,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_REQ    = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_COMMIT = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [2:0] pos_count;
  logic [1:0] pos_index;
  logic       iter_at_cap;

  // Number of neurons still alive.
  assign pos_count = {2'b00, pos_flags[0]} + {2'b00, pos_flags[1]}
                   + {2'b00, pos_flags[2]} + {2'b00, pos_flags[3]};

  // Index of the set bit; only meaningful when exactly one flag is set.
  always_comb begin
    pos_index = 2'd0;
    case (pos_flags)
      4'b0010: pos_index = 2'd1;
      4'b0100: pos_index = 2'd2;
      4'b1000: pos_index = 2'd3;
      default: pos_index = 2'd0;
    endcase
  end

  assign iter_at_cap = (iter_cnt == ITER_CAP);

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: state_nxt = S_CHECK;
      S_CHECK: begin
        if (pos_count <= 3'd1)  state_nxt = S_DONE;
        else if (iter_at_cap)   state_nxt = S_DONE;
        else                    state_nxt = S_REQ;
      end
      S_REQ: begin
        if (fp_ack) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (calc_idx == 2'd3) state_nxt = S_COMMIT;
        else                  state_nxt = S_REQ;
      end
      S_COMMIT: state_nxt = S_CHECK;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered result / index outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      calc_idx  <= 2'd0;
      iter_cnt  <= '0;
      winner    <= 2'd0;
      win_valid <= 1'b0;
      timeout   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // A new run clears the previous results, so they read 0 from LOAD on.
          if (start) begin
            iter_cnt  <= '0;
            winner    <= 2'd0;
            win_valid <= 1'b0;
            timeout   <= 1'b0;
            done      <= 1'b0;
          end
        end
        S_CHECK: begin
          if (pos_count <= 3'd1) begin
            done      <= 1'b1;
            timeout   <= 1'b0;
            win_valid <= (pos_count == 3'd1);
            winner    <= (pos_count == 3'd1) ? pos_index : 2'd0;
          end else if (iter_at_cap) begin
            // Still two or more positive after the cap: no winner reported.
            done      <= 1'b1;
            timeout   <= 1'b1;
            win_valid <= 1'b0;
            winner    <= 2'd0;
          end else begin
            calc_idx <= 2'd0;
          end
        end
        S_WRITE: begin
          if (calc_idx != 2'd3) calc_idx <= calc_idx + 2'd1;
        end
        S_COMMIT: begin
          // CHECK stops before REQ at the cap, so this cannot pass MAX_ITER.
          iter_cnt <= iter_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes decoded straight from the registered state.
  assign ld_x      = (state == S_LOAD);
  assign fp_req    = (state == S_REQ);
  assign wr_en     = (state == S_WRITE);
  assign commit    = (state == S_COMMIT);
  assign dbg_state = state;

endmodule
